// File: rtl/cpu_mem_pkg.sv
// Shared types for the memory port arbiter: owner tags and default bus widths.
// Owner tags ride alongside each memory command so read data can be steered home.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_e;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    // A branch flush turns every in-flight fetch into an orphan read.
    function automatic owner_e kill_if(input owner_e tag, input logic flush);
        return (flush && tag == OWN_IF) ? OWN_NONE : tag;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag shift register matching the memory read latency; flush kills IF tags.
// Latency DEPTH cycles from tag_i to tag_o; no backpressure, advances every cycle.
module arb_tag_pipe
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   flush_i,
    input  owner_e tag_i,
    output owner_e tag_o
);

    owner_e stage_q [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q[0] <= kill_if(tag_i, flush_i);
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= kill_if(stage_q[i-1], flush_i);
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch/load/store onto one registered memory port and demuxes read data.
// Grant is combinational; command issues 1 cycle after grant; read returns RD_LAT later.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adrs,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stall_if,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_adrs,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_adrs,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              promote;
    logic              any_gnt;
    logic [ADDR_W-1:0] gnt_adrs;
    owner_e            gnt_tag;
    owner_e            cmd_tag_q;
    owner_e            ret_tag;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_adrs_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // A fetch denied STARVE_MAX times in a row jumps ahead of stores and loads.
    assign promote = (starve_q == CNT_W'(STARVE_MAX));

    always_comb begin
        if_gnt   = 1'b0;
        ld_gnt   = 1'b0;
        st_gnt   = 1'b0;
        gnt_adrs = if_adrs;
        gnt_tag  = OWN_NONE;
        if (promote && if_req) begin
            if_gnt  = 1'b1;
            gnt_tag = OWN_IF;
        end else if (st_req) begin
            st_gnt   = 1'b1;
            gnt_adrs = st_adrs;
        end else if (ld_req) begin
            ld_gnt   = 1'b1;
            gnt_adrs = ld_adrs;
            gnt_tag  = OWN_LD;
        end else if (if_req) begin
            if_gnt  = 1'b1;
            gnt_tag = OWN_IF;
        end
    end

    assign any_gnt  = if_gnt | ld_gnt | st_gnt;
    assign stall_if = if_req & ~if_gnt;

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (!promote) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adrs_q  <= '0;
            mem_wdata_q <= '0;
            cmd_tag_q   <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            mem_en_q <= any_gnt;
            mem_we_q <= st_gnt;
            if (any_gnt) begin
                mem_adrs_q <= gnt_adrs;
            end
            if (st_gnt) begin
                mem_wdata_q <= st_wdata;
            end
            cmd_tag_q <= kill_if(gnt_tag, flush);
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_adrs  = mem_adrs_q;
    assign mem_wdata = mem_wdata_q;

    arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (flush),
        .tag_i   (cmd_tag_q),
        .tag_o   (ret_tag)
    );

    assign if_rvalid = (ret_tag == OWN_IF);
    assign ld_rvalid = (ret_tag == OWN_LD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ld_rdata  = ld_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (RD_LAT 1 and 3) with identical traffic and checks them against
// a transaction-level model: priority rule, starvation count, and a return scoreboard.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'h5A5A_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    logic if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
    logic [AW-1:0] if_adrs = '0, ld_adrs = '0, st_adrs = '0;
    logic [DW-1:0] st_wdata = '0;

    logic          if_gnt_w [2], if_rvalid_w [2], stall_if_w [2];
    logic          ld_gnt_w [2], ld_rvalid_w [2], st_gnt_w [2];
    logic          mem_en_w [2], mem_we_w [2];
    logic [DW-1:0] if_rdata_w [2], ld_rdata_w [2], mem_wdata_w [2], mem_rdata_w [2];
    logic [AW-1:0] mem_adrs_w [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem   [2**AW];
        logic [DW-1:0] rpipe [L];

        initial for (int i = 0; i < 2**AW; i++) mem[i] = init_word(i);

        // Behavioural memory macro: write at the edge, read data L cycles after mem_en.
        always @(posedge clk) begin
            if (mem_en_w[g] && mem_we_w[g]) mem[mem_adrs_w[g]] = mem_wdata_w[g];
            for (int i = L - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
            rpipe[0] = (mem_en_w[g] && !mem_we_w[g]) ? mem[mem_adrs_w[g]] : 32'hBAD0_BAD0;
        end
        assign mem_rdata_w[g] = rpipe[L-1];

        mem_port_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RD_LAT(L), .STARVE_MAX(SMAX)
        ) u_dut (
            .clk(clk), .resetn(resetn), .flush(flush),
            .if_req(if_req), .if_adrs(if_adrs), .if_gnt(if_gnt_w[g]),
            .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]), .stall_if(stall_if_w[g]),
            .ld_req(ld_req), .ld_adrs(ld_adrs), .ld_gnt(ld_gnt_w[g]),
            .ld_rvalid(ld_rvalid_w[g]), .ld_rdata(ld_rdata_w[g]),
            .st_req(st_req), .st_adrs(st_adrs), .st_wdata(st_wdata), .st_gnt(st_gnt_w[g]),
            .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_adrs(mem_adrs_w[g]),
            .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata_w[g])
        );
    end

    typedef struct {
        int            gcyc;
        owner_e        own;
        logic [DW-1:0] data;
        bit [1:0]      killed;
    } ret_t;

    ret_t          rq [$];
    logic [DW-1:0] ref_mem [2**AW];
    int            cyc = 0;
    int            starve = 0;
    bit            pg_en = 0, pg_we = 0;
    logic [AW-1:0] pg_adrs = '0;
    logic [DW-1:0] pg_wdata = '0;
    int            n_chk = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string when);
        for (int g = 0; g < 2; g++) begin
            check_val($sformatf("%s outs[%0d]", when, g),
                {if_gnt_w[g], if_rvalid_w[g], stall_if_w[g], ld_gnt_w[g], ld_rvalid_w[g],
                 st_gnt_w[g], mem_en_w[g], mem_we_w[g]}, 64'd0);
            check_val($sformatf("%s mem_adrs[%0d]", when, g), mem_adrs_w[g], 64'd0);
            check_val($sformatf("%s mem_wdata[%0d]", when, g), mem_wdata_w[g], 64'd0);
            check_val($sformatf("%s rdata[%0d]", when, g), {if_rdata_w[g], ld_rdata_w[g]}, 64'd0);
        end
    endtask

    // One clock cycle: optional random request generation, model prediction, compare, update.
    task automatic step(input int p_if, input int p_ld, input int p_st, input int p_fl);
        bit            g_if, g_ld, g_st;
        bit            e_ifv [2], e_ldv [2];
        logic [DW-1:0] e_ifd [2], e_ldd [2];
        if (!if_req && int'($urandom_range(99)) < p_if) begin
            if_req = 1'b1; if_adrs = AW'($urandom_range(31));
        end
        if (!ld_req && int'($urandom_range(99)) < p_ld) begin
            ld_req = 1'b1; ld_adrs = AW'($urandom_range(31));
        end
        if (!st_req && int'($urandom_range(99)) < p_st) begin
            st_req = 1'b1; st_adrs = AW'($urandom_range(31)); st_wdata = $urandom;
        end
        if (p_fl >= 0) flush = (int'($urandom_range(99)) < p_fl);

        g_if = 0; g_ld = 0; g_st = 0;
        if (if_req && starve == SMAX) g_if = 1;
        else if (st_req)              g_st = 1;
        else if (ld_req)              g_ld = 1;
        else if (if_req)              g_if = 1;

        for (int g = 0; g < 2; g++) begin
            e_ifv[g] = 0; e_ldv[g] = 0; e_ifd[g] = '0; e_ldd[g] = '0;
            foreach (rq[k]) begin
                if (rq[k].gcyc + 1 + lat(g) == cyc && !rq[k].killed[g]) begin
                    if (rq[k].own == OWN_IF) begin e_ifv[g] = 1; e_ifd[g] = rq[k].data; end
                    else                     begin e_ldv[g] = 1; e_ldd[g] = rq[k].data; end
                end
            end
        end

        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_val($sformatf("if_gnt[%0d]", g), if_gnt_w[g], g_if);
            check_val($sformatf("ld_gnt[%0d]", g), ld_gnt_w[g], g_ld);
            check_val($sformatf("st_gnt[%0d]", g), st_gnt_w[g], g_st);
            check_val($sformatf("stall_if[%0d]", g), stall_if_w[g], if_req && !g_if);
            check_val($sformatf("mem_en[%0d]", g), mem_en_w[g], pg_en);
            check_val($sformatf("mem_we[%0d]", g), mem_we_w[g], pg_we);
            if (pg_en) check_val($sformatf("mem_adrs[%0d]", g), mem_adrs_w[g], pg_adrs);
            if (pg_en && pg_we) check_val($sformatf("mem_wdata[%0d]", g), mem_wdata_w[g], pg_wdata);
            check_val($sformatf("if_rvalid[%0d]", g), if_rvalid_w[g], e_ifv[g]);
            check_val($sformatf("ld_rvalid[%0d]", g), ld_rvalid_w[g], e_ldv[g]);
            if (e_ifv[g]) check_val($sformatf("if_rdata[%0d]", g), if_rdata_w[g], e_ifd[g]);
            if (e_ldv[g]) check_val($sformatf("ld_rdata[%0d]", g), ld_rdata_w[g], e_ldd[g]);
        end

        starve = (if_req && !g_if) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        if (flush) begin
            foreach (rq[k]) begin
                for (int g = 0; g < 2; g++)
                    if (rq[k].own == OWN_IF && cyc <= rq[k].gcyc + lat(g)) rq[k].killed[g] = 1'b1;
            end
        end
        if (g_if) rq.push_back('{cyc, OWN_IF, ref_mem[if_adrs], flush ? 2'b11 : 2'b00});
        if (g_ld) rq.push_back('{cyc, OWN_LD, ref_mem[ld_adrs], 2'b00});
        if (g_st) ref_mem[st_adrs] = st_wdata;
        pg_en    = g_if || g_ld || g_st;
        pg_we    = g_st;
        pg_adrs  = g_st ? st_adrs : (g_ld ? ld_adrs : if_adrs);
        if (g_st) pg_wdata = st_wdata;
        while (rq.size() > 0 && rq[0].gcyc + 6 < cyc) void'(rq.pop_front());

        @(posedge clk);
        #1;
        cyc++;
        if (g_if) if_req = 1'b0;
        if (g_ld) ld_req = 1'b0;
        if (g_st) st_req = 1'b0;
        flush = 1'b0;
    endtask

    // Called #1 after a rising edge: reset lands mid-cycle, in-flight reads must vanish.
    task automatic reset_mid();
        if_req = 0; ld_req = 0; st_req = 0; flush = 0;
        resetn = 1'b0;
        #1;
        check_all_zero("mid-reset");
        rq.delete();
        starve = 0; pg_en = 0; pg_we = 0;
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        resetn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, -1);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(i);
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Lone fetch.
        if_req = 1; if_adrs = 11'h010;
        step(0, 0, 0, -1);
        idle(5);

        // Three-way collision, store then load to the same word.
        if_req = 1; if_adrs = 11'h011;
        ld_req = 1; ld_adrs = 11'h020;
        st_req = 1; st_adrs = 11'h020; st_wdata = 32'hDEAD_BEEF;
        idle(8);

        // Fetch starvation under continuous load/store pressure.
        if_req = 1; if_adrs = 11'h012;
        repeat (12) step(0, 100, 100, -1);
        idle(6);

        // Flush the edge after a fetch grant; a load issued alongside survives.
        if_req = 1; if_adrs = 11'h030;
        step(0, 0, 0, -1);
        ld_req = 1; ld_adrs = 11'h005; flush = 1;
        step(0, 0, 0, -1);
        idle(6);

        // Reset while a load is in flight.
        ld_req = 1; ld_adrs = 11'h007;
        step(0, 0, 0, -1);
        reset_mid();
        idle(6);

        // Back-to-back reads at 0x001..0x004 with alternating owners.
        if_req = 1; if_adrs = 11'h001;
        step(0, 0, 0, -1);
        ld_req = 1; ld_adrs = 11'h002;
        step(0, 0, 0, -1);
        if_req = 1; if_adrs = 11'h003;
        step(0, 0, 0, -1);
        ld_req = 1; ld_adrs = 11'h004;
        step(0, 0, 0, -1);
        idle(6);

        // Randomized traffic with flushes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(599) == 0) begin
                reset_mid();
            end else if (n % 400 < 40) begin
                step(90, 90, 90, 3);
            end else begin
                step(60, 35, 25, 6);
            end
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
